// File: rtl/os_tile_seq_if.sv
// Handshake and instruction bundle between the core controller / MAC array and os_tile_seq.
// The sequencer is the slave side; the controller/array environment is the master side.
interface os_tile_seq_if #(
  parameter int row = 8,
  parameter int kw  = 8,
  parameter int rw  = 3
);
  logic               start;
  logic [kw-1:0]      k_len;
  logic [2*row-1:0]   inst_w;
  logic               l0_rd;
  logic [rw-1:0]      drain_row;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  modport master (
    output start, k_len, out_ready,
    input  inst_w, l0_rd, drain_row, out_valid, busy, done
  );

  modport slave (
    input  start, k_len, out_ready,
    output inst_w, l0_rd, drain_row, out_valid, busy, done
  );
endinterface

// File: rtl/os_tile_seq.sv
// Output-stationary tile sequencer: clear, k_len accumulate steps with per-row skew,
// settle, then row-by-row psum drain over valid/ready. All outputs are registered.
module os_tile_seq #(
  parameter int row = 8,
  parameter int kw  = 8,
  parameter int rw  = 3
) (
  input logic         clk,
  input logic         reset,
  os_tile_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_SETTLE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [rw-1:0] LAST_ROW = rw'(row - 1);

  state_t          state_q, state_d;
  logic [kw-1:0]   kcnt_q, kcnt_d;
  logic [rw-1:0]   scnt_q, scnt_d;
  logic [rw-1:0]   drain_row_q, drain_row_d;
  logic            l0_rd_q, l0_rd_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      base_d;
  logic [1:0]      skew_q [row];
  logic [1:0]      skew_d [row];
  logic [2*row-1:0] inst_flat;

  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    scnt_d      = scnt_q;
    drain_row_d = drain_row_q;
    base_d      = 2'b00;
    l0_rd_d     = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start && bus.k_len != '0) begin
          state_d = S_CLEAR;
          kcnt_d  = bus.k_len;
          base_d  = 2'b01;
          busy_d  = 1'b1;
        end
      end
      S_CLEAR: begin
        state_d = S_COMPUTE;
        base_d  = 2'b10;
        l0_rd_d = 1'b1;
      end
      S_COMPUTE: begin
        // Counter is loaded with k_len and exits at 1, so all-ones never wraps.
        if (kcnt_q == kw'(1)) begin
          state_d = S_SETTLE;
          kcnt_d  = '0;
          scnt_d  = LAST_ROW;
        end else begin
          kcnt_d  = kcnt_q - kw'(1);
          base_d  = 2'b10;
          l0_rd_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (scnt_q == '0) begin
          state_d     = S_DRAIN;
          out_valid_d = 1'b1;
          drain_row_d = '0;
        end else begin
          scnt_d = scnt_q - rw'(1);
        end
      end
      S_DRAIN: begin
        out_valid_d = 1'b1;
        if (bus.out_ready) begin
          if (drain_row_q == LAST_ROW) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            drain_row_d = '0;
            done_d      = 1'b1;
          end else begin
            drain_row_d = drain_row_q + rw'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Row 0 takes the fresh base instruction; each later row lags its predecessor by one cycle.
  generate
    for (genvar gi = 0; gi < row; gi++) begin : g_skew
      if (gi == 0) begin : g_head
        assign skew_d[gi] = base_d;
      end else begin : g_tail
        assign skew_d[gi] = skew_q[gi-1];
      end
      assign inst_flat[2*gi+1:2*gi] = skew_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      kcnt_q      <= '0;
      scnt_q      <= '0;
      drain_row_q <= '0;
      l0_rd_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < row; i++) skew_q[i] <= 2'b00;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      scnt_q      <= scnt_d;
      drain_row_q <= drain_row_d;
      l0_rd_q     <= l0_rd_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < row; i++) skew_q[i] <= skew_d[i];
    end
  end

  assign bus.inst_w    = inst_flat;
  assign bus.l0_rd     = l0_rd_q;
  assign bus.drain_row = drain_row_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_os_tile_seq.sv
// Bench for os_tile_seq: job table, hand-written corner sequences, and random traffic,
// all checked every cycle against a job-timeline reference model.
module tb_os_tile_seq;

  localparam int ROW = 4;
  localparam int KW  = 8;
  localparam int RW  = 2;
  localparam int HIST = 8192;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  os_tile_seq_if #(.row(ROW), .kw(KW), .rw(RW)) bus ();

  os_tile_seq #(.row(ROW), .kw(KW), .rw(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a job is described by its cycle index n since the accepting edge.
  int       cyc_no = 0;
  int       rst_c  = 0;
  bit       chk_en = 1'b0;
  bit       m_act  = 1'b0;
  int       m_n, m_k, m_drained, m_done_n;
  logic [1:0] hist [HIST];

  int inst0 [512];
  int inst3 [512];

  typedef struct {
    int k;
    int stall_row;
    int stall_len;
    bit poke;
    int exp_done;
    int exp_l0;
  } job_t;

  job_t jobs [6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic int model_base();
    if (!m_act) return 0;
    if (m_n == 1) return 1;
    if (m_n >= 2 && m_n <= m_k + 1) return 2;
    return 0;
  endfunction

  task automatic model_step(input bit s, input int k, input bit rdy, input bit rst);
    int n0;
    cyc_no++;
    if (rst) begin
      m_act  = 1'b0;
      rst_c  = cyc_no;
      chk_en = 1'b1;
    end else if (!m_act) begin
      if (s && k != 0) begin
        m_act = 1'b1; m_n = 1; m_k = k; m_drained = 0; m_done_n = 0;
      end
    end else begin
      n0 = m_k + 2 + ROW;
      if (m_n >= n0 && m_drained < ROW && rdy) begin
        m_drained++;
        if (m_drained == ROW) m_done_n = m_n + 1;
      end
      if (m_done_n != 0 && m_n == m_done_n) m_act = 1'b0;
      else m_n++;
    end
    hist[cyc_no] = 2'(model_base());
  endtask

  function automatic logic [13:0] model_vec();
    logic [2*ROW-1:0] iw;
    logic l0, vld, bsy, dn;
    logic [RW-1:0] dr;
    int idx, n0;
    iw = '0;
    for (int r = 0; r < ROW; r++) begin
      idx = cyc_no - r;
      if (idx >= rst_c && idx >= 0) iw[2*r +: 2] = hist[idx];
    end
    n0  = m_k + 2 + ROW;
    l0  = m_act && m_n >= 2 && m_n <= m_k + 1;
    vld = m_act && m_n >= n0 && m_drained < ROW;
    dr  = vld ? RW'(m_drained) : '0;
    bsy = m_act;
    dn  = m_act && m_done_n != 0 && m_n == m_done_n;
    return {iw, l0, dr, vld, bsy, dn};
  endfunction

  task automatic drive(input bit s, input int k, input bit rdy, input bit rst);
    logic [13:0] act, exp;
    bus.start     = s;
    bus.k_len     = KW'(k);
    bus.out_ready = rdy;
    reset         = rst;
    @(posedge clk);
    model_step(s, k, rdy, rst);
    @(negedge clk);
    if (chk_en) begin
      act = {bus.inst_w, bus.l0_rd, bus.drain_row, bus.out_valid, bus.busy, bus.done};
      exp = model_vec();
      tests++;
      if (act !== exp) begin
        fails++;
        $display("FAIL cycle_outputs @%0d: got %b required %b", cyc_no, act, exp);
      end
    end
  endtask

  task automatic run_job(input int k, input int stall_row, input int stall_len, input bit poke,
                         output int done_n, output int l0_cnt, output int done_cnt);
    int n, stalled;
    bit rdy, s, seen_done;
    n = 0; stalled = 0; done_n = -1; l0_cnt = 0; done_cnt = 0; seen_done = 0;
    drive(1'b1, k, 1'b1, 1'b0);
    while (n < 600) begin
      n++;
      if (n < 512) begin
        inst0[n] = int'(bus.inst_w[1:0]);
        inst3[n] = int'(bus.inst_w[7:6]);
      end
      if (bus.l0_rd) l0_cnt++;
      if (bus.done) begin
        done_cnt++; done_n = n; seen_done = 1;
      end
      if (seen_done && !bus.busy) break;
      rdy = 1'b1;
      if (bus.out_valid && int'(bus.drain_row) == stall_row && stalled < stall_len) begin
        rdy = 1'b0; stalled++;
      end
      s = poke && (bus.l0_rd || bus.done);
      drive(s, 7, rdy, 1'b0);
    end
    if (n >= 600) check("job_timeout", 0, 1);
  endtask

  initial begin
    int dn, l0c, dc;

    jobs[0] = '{k: 3,   stall_row: 0, stall_len: 0, poke: 0, exp_done: 13,            exp_l0: 3};
    jobs[1] = '{k: 3,   stall_row: 1, stall_len: 3, poke: 0, exp_done: 16,            exp_l0: 3};
    jobs[2] = '{k: 3,   stall_row: 0, stall_len: 0, poke: 1, exp_done: 13,            exp_l0: 3};
    jobs[3] = '{k: 255, stall_row: 0, stall_len: 0, poke: 0, exp_done: 257 + 2*ROW,   exp_l0: 255};
    jobs[4] = '{k: 10,  stall_row: 3, stall_len: 2, poke: 0, exp_done: 12 + 2*ROW + 2, exp_l0: 10};
    jobs[5] = '{k: 1,   stall_row: 2, stall_len: 1, poke: 0, exp_done: 3 + 2*ROW + 1,  exp_l0: 1};

    for (int i = 0; i < HIST; i++) hist[i] = 2'b00;

    // Reset held two cycles with start asserted, then three quiet cycles.
    drive(1'b1, 5, 1'b1, 1'b1);
    drive(1'b1, 5, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0);
      check("reset_inst_w", int'(bus.inst_w), 0);
      check("reset_busy", int'(bus.busy), 0);
    end
    $display("[TB] reset sequence done");

    // start with k_len = 0 is ignored.
    drive(1'b1, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    check("klen0_busy", int'(bus.busy), 0);
    drive(1'b0, 0, 1'b1, 1'b0);
    check("klen0_l0_rd", int'(bus.l0_rd), 0);
    $display("[TB] k_len=0 start ignored");

    for (int j = 0; j < 6; j++) begin
      run_job(jobs[j].k, jobs[j].stall_row, jobs[j].stall_len, jobs[j].poke, dn, l0c, dc);
      check("job_done_cycle", dn, jobs[j].exp_done);
      check("job_l0_count", l0c, jobs[j].exp_l0);
      check("job_done_pulses", dc, 1);
      if (j == 0) begin
        check("row0_c1", inst0[1], 1);
        for (int c = 2; c <= 4; c++) check("row0_acc", inst0[c], 2);
        check("row3_c3", inst3[3], 0);
        check("row3_c4", inst3[4], 1);
        for (int c = 5; c <= 7; c++) check("row3_acc", inst3[c], 2);
      end
      $display("[TB] job k_len=%0d stall_row=%0d stall_len=%0d poke=%0d done@%0d l0=%0d",
               jobs[j].k, jobs[j].stall_row, jobs[j].stall_len, jobs[j].poke, dn, l0c);
      drive(1'b0, 0, 1'b1, 1'b0);
    end

    // Reset during COMPUTE, then a fresh job must run with normal timing.
    drive(1'b1, 5, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 1'b0);
    check("midrun_l0_before", int'(bus.l0_rd), 1);
    drive(1'b0, 0, 1'b1, 1'b1);
    check("midrun_inst_w", int'(bus.inst_w), 0);
    check("midrun_l0_rd", int'(bus.l0_rd), 0);
    check("midrun_busy", int'(bus.busy), 0);
    drive(1'b0, 0, 1'b1, 1'b0);
    run_job(1, 0, 0, 1'b0, dn, l0c, dc);
    check("post_reset_done", dn, 3 + 2*ROW);
    $display("[TB] reset mid-COMPUTE recovered, done@%0d", dn);
    drive(1'b0, 0, 1'b1, 1'b0);

    // Random traffic: starts (incl. k_len=0), ready backpressure, occasional reset.
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom % 6) == 0, int'($urandom_range(0, 12)), ($urandom % 3) != 0,
            ($urandom % 250) == 0);
    end
    $display("[TB] random phase done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
